// File: rtl/ex_stage_if.sv
// Decode-to-execute bundle plus the execute stage's redirect, stall,
// writeback and memory outputs.
interface ex_stage_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] id_pc_r;
  logic [XLEN-1:0] id_imm_r;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      id_rd_index_r;
  logic [3:0]      id_alu_op_r;
  logic            id_a_signed_r;
  logic            id_b_signed_r;
  logic            id_op_imm_r;
  logic            id_mem_rd_r;
  logic            id_mem_wr_r;
  logic            id_mem_signed_r;
  logic [1:0]      id_mem_size_r;
  logic [2:0]      id_branch_r;
  logic            id_reg_jump_r;

  logic            branch_taken_w;
  logic [XLEN-1:0] jump_addr_w;
  logic            ex_stall_w;
  logic            ex_rd_we_r;
  logic [4:0]      ex_rd_index_r;
  logic [XLEN-1:0] ex_rd_data_r;
  logic            ex_mem_rd_r;
  logic            ex_mem_wr_r;
  logic            ex_mem_signed_r;
  logic [1:0]      ex_mem_size_r;
  logic [XLEN-1:0] ex_mem_addr_r;
  logic [XLEN-1:0] ex_mem_wdata_r;

  modport master (
    output id_pc_r, id_imm_r, rs1_data_i, rs2_data_i, id_rd_index_r, id_alu_op_r,
           id_a_signed_r, id_b_signed_r, id_op_imm_r, id_mem_rd_r, id_mem_wr_r,
           id_mem_signed_r, id_mem_size_r, id_branch_r, id_reg_jump_r,
    input  branch_taken_w, jump_addr_w, ex_stall_w, ex_rd_we_r, ex_rd_index_r,
           ex_rd_data_r, ex_mem_rd_r, ex_mem_wr_r, ex_mem_signed_r, ex_mem_size_r,
           ex_mem_addr_r, ex_mem_wdata_r
  );

  modport slave (
    input  id_pc_r, id_imm_r, rs1_data_i, rs2_data_i, id_rd_index_r, id_alu_op_r,
           id_a_signed_r, id_b_signed_r, id_op_imm_r, id_mem_rd_r, id_mem_wr_r,
           id_mem_signed_r, id_mem_size_r, id_branch_r, id_reg_jump_r,
    output branch_taken_w, jump_addr_w, ex_stall_w, ex_rd_we_r, ex_rd_index_r,
           ex_rd_data_r, ex_mem_rd_r, ex_mem_wr_r, ex_mem_signed_r, ex_mem_size_r,
           ex_mem_addr_r, ex_mem_wdata_r
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, single-cycle multiply, branch resolution, memory request
// formation and a 32-step restoring divider that stalls the front end.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic     clk_i,
  input  logic     reset_ni,
  ex_stage_if.slave io
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                         OP_MUL = 4'd8, OP_DIV = 4'd9, OP_REM = 4'd10;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q;
  logic [4:0]      cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dvsr_q, dvd_q;
  logic            neg_quo_q, neg_rem_q, dz_q, is_rem_q;
  logic [4:0]      div_rd_q;

  logic            br_q, rd_we_q, mrd_q, mwr_q, msgn_q;
  logic [XLEN-1:0] jaddr_q, rd_data_q, maddr_q, mwdata_q;
  logic [4:0]      rd_idx_q;
  logic [1:0]      msize_q;

  logic [XLEN-1:0] op_a, op_b, alu_d, result_d, sum_ai_d, jump_d, a_mag_d, b_mag_d;
  logic            br_eq, br_lt, take_d, wr_d, is_div_d, a_neg_d, b_neg_d, accept_d;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] quo_step, rem_step, div_res_d;

  always_comb begin
    op_a = io.rs1_data_i;
    op_b = io.id_op_imm_r ? io.id_imm_r : io.rs2_data_i;
    alu_d = '0;
    case (io.id_alu_op_r)
      OP_ADD: alu_d = op_a + op_b;
      OP_SUB: alu_d = op_a - op_b;
      OP_AND: alu_d = op_a & op_b;
      OP_OR:  alu_d = op_a | op_b;
      OP_XOR: alu_d = op_a ^ op_b;
      OP_SLT: alu_d = {{(XLEN-1){1'b0}}, io.id_a_signed_r ? ($signed(op_a) < $signed(op_b))
                                                           : (op_a < op_b)};
      OP_SLL: alu_d = op_a << op_b[4:0];
      OP_SRL: alu_d = io.id_a_signed_r ? XLEN'($signed(op_a) >>> op_b[4:0]) : (op_a >> op_b[4:0]);
      OP_MUL: alu_d = op_a * op_b;
      default: alu_d = '0;
    endcase

    br_eq = io.rs1_data_i == io.rs2_data_i;
    br_lt = io.id_a_signed_r ? ($signed(io.rs1_data_i) < $signed(io.rs2_data_i))
                             : (io.rs1_data_i < io.rs2_data_i);
    case (io.id_branch_r)
      3'd1:    take_d = br_eq;
      3'd2:    take_d = !br_eq;
      3'd3:    take_d = br_lt;
      3'd4:    take_d = !br_lt;
      3'd5:    take_d = 1'b1;
      default: take_d = 1'b0;
    endcase

    sum_ai_d = io.rs1_data_i + io.id_imm_r;
    jump_d   = io.id_reg_jump_r ? {sum_ai_d[XLEN-1:1], 1'b0} : (io.id_pc_r + io.id_imm_r);
    result_d = (io.id_branch_r == 3'd5) ? (io.id_pc_r + XLEN'(4)) : alu_d;
    is_div_d = (io.id_alu_op_r == OP_DIV) || (io.id_alu_op_r == OP_REM);
    wr_d     = (io.id_rd_index_r != 5'd0) && !io.id_mem_wr_r && !is_div_d &&
               ((io.id_branch_r == 3'd0) || (io.id_branch_r == 3'd5));
    accept_d = (state_q != S_BUSY) && !br_q;

    a_neg_d = io.id_a_signed_r & op_a[XLEN-1];
    b_neg_d = io.id_b_signed_r & op_b[XLEN-1];
    a_mag_d = a_neg_d ? -op_a : op_a;
    b_mag_d = b_neg_d ? -op_b : op_b;

    // A borrow out of bit XLEN means the shifted remainder is below the divisor.
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    diff     = rem_sh - {1'b0, dvsr_q};
    quo_step = {quo_q[XLEN-2:0], ~diff[XLEN]};
    rem_step = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];

    if (dz_q)          div_res_d = is_rem_q ? dvd_q : '1;
    else if (is_rem_q) div_res_d = neg_rem_q ? -rem_step : rem_step;
    else               div_res_d = neg_quo_q ? -quo_step : quo_step;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;  cnt_q <= '0;
      quo_q <= '0;  rem_q <= '0;  dvsr_q <= '0;  dvd_q <= '0;
      neg_quo_q <= 1'b0;  neg_rem_q <= 1'b0;  dz_q <= 1'b0;  is_rem_q <= 1'b0;
      div_rd_q <= '0;
      br_q <= 1'b0;  jaddr_q <= '0;
      rd_we_q <= 1'b0;  rd_idx_q <= '0;  rd_data_q <= '0;
      mrd_q <= 1'b0;  mwr_q <= 1'b0;  msgn_q <= 1'b0;  msize_q <= '0;
      maddr_q <= '0;  mwdata_q <= '0;
    end else begin
      br_q    <= 1'b0;
      rd_we_q <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      case (state_q)
        S_BUSY: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q   <= S_DONE;
            rd_we_q   <= div_rd_q != 5'd0;
            rd_idx_q  <= div_rd_q;
            rd_data_q <= div_res_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          // DONE also accepts, so a held divide starts without a bubble.
          if (accept_d) begin
            if (is_div_d) begin
              state_q   <= S_BUSY;
              cnt_q     <= '0;
              quo_q     <= a_mag_d;
              rem_q     <= '0;
              dvsr_q    <= b_mag_d;
              dvd_q     <= op_a;
              neg_quo_q <= a_neg_d ^ b_neg_d;
              neg_rem_q <= a_neg_d;
              dz_q      <= op_b == '0;
              is_rem_q  <= io.id_alu_op_r == OP_REM;
              div_rd_q  <= io.id_rd_index_r;
            end else begin
              br_q      <= take_d;
              jaddr_q   <= jump_d;
              rd_we_q   <= wr_d;
              rd_idx_q  <= io.id_rd_index_r;
              rd_data_q <= result_d;
              mrd_q     <= io.id_mem_rd_r;
              mwr_q     <= io.id_mem_wr_r;
              msgn_q    <= io.id_mem_signed_r;
              msize_q   <= io.id_mem_size_r;
              maddr_q   <= sum_ai_d;
              mwdata_q  <= io.rs2_data_i;
            end
          end
        end
      endcase
    end
  end

  assign io.branch_taken_w  = br_q;
  assign io.jump_addr_w     = jaddr_q;
  assign io.ex_stall_w      = state_q == S_BUSY;
  assign io.ex_rd_we_r      = rd_we_q;
  assign io.ex_rd_index_r   = rd_idx_q;
  assign io.ex_rd_data_r    = rd_data_q;
  assign io.ex_mem_rd_r     = mrd_q;
  assign io.ex_mem_wr_r     = mwr_q;
  assign io.ex_mem_signed_r = msgn_q;
  assign io.ex_mem_size_r   = msize_q;
  assign io.ex_mem_addr_r   = maddr_q;
  assign io.ex_mem_wdata_r  = mwdata_q;
endmodule
